// File: rtl/date_offset_calc.sv
// Sequential date-offset engine: base date +/- day count -> calendar date, one step per cycle.
// Optional build macro DATE_OFFSET_YEAR_SKIP_EN adds whole-year steps (same results, lower latency).
module date_offset_calc #(
    parameter int unsigned MAX_OFFSET = 99999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir,
    input  logic [22:0] base_date,
    input  logic [16:0] offset,
    output logic        busy,
    output logic        done,
    output logic [22:0] result_date,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FWD   = 3'd2,
        BWD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [16:0] MAX_OFF = 17'(MAX_OFFSET);
    localparam logic [13:0] YEAR_MAX = 14'h3FFF;

    state_t      state_q, state_d;
    logic [13:0] cur_year_q, cur_year_d;
    logic [3:0]  cur_month_q, cur_month_d;
    logic [4:0]  cur_day_q, cur_day_d;
    logic [16:0] rem_q, rem_d;
    logic        dir_q, dir_d;
    logic [22:0] base_q, base_d;
    logic [22:0] result_q, result_d;
    logic        err_q, err_d;

    logic        cur_leap;
    logic [4:0]  cur_dim;
    logic [16:0] dleft;
    logic [3:0]  prev_month;
    logic [13:0] prev_year;
    logic [4:0]  prev_dim;
    logic        invalid;
`ifdef DATE_OFFSET_YEAR_SKIP_EN
    logic [16:0] diy;
    logic        skip_fwd;
    logic        skip_bwd;
`endif

    function automatic logic is_leap(input logic [13:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                    return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cur_year_d  = cur_year_q;
        cur_month_d = cur_month_q;
        cur_day_d   = cur_day_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        base_d      = base_q;
        result_d    = result_q;
        err_d       = err_q;

        cur_leap   = is_leap(cur_year_q);
        cur_dim    = days_in_month(cur_month_q, cur_leap);
        dleft      = 17'(cur_dim) - 17'(cur_day_q);
        prev_month = (cur_month_q == 4'd1) ? 4'd12 : cur_month_q - 4'd1;
        prev_year  = (cur_month_q == 4'd1) ? cur_year_q - 14'd1 : cur_year_q;
        prev_dim   = days_in_month(prev_month, is_leap(prev_year));
        invalid    = (cur_year_q == 14'd0) || (cur_month_q == 4'd0) || (cur_month_q > 4'd12) ||
                     (cur_day_q == 5'd0) || (cur_day_q > cur_dim) || (rem_q > MAX_OFF);
`ifdef DATE_OFFSET_YEAR_SKIP_EN
        diy      = 17'd365 + 17'(cur_leap);
        skip_fwd = (cur_month_q == 4'd1) && (cur_day_q == 5'd1) && (rem_q >= diy);
        skip_bwd = (cur_month_q == 4'd12) && (cur_day_q == 5'd31) && (rem_q >= diy);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_year_d  = base_date[22:9];
                    cur_month_d = base_date[8:5];
                    cur_day_d   = base_date[4:0];
                    rem_d       = offset;
                    dir_d       = dir;
                    base_d      = base_date;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (invalid || rem_q == 17'd0) begin
                    err_d    = invalid;
                    result_d = base_q;
                    state_d  = DONE;
                end else begin
                    state_d = dir_q ? BWD : FWD;
                end
            end
            FWD: begin
`ifdef DATE_OFFSET_YEAR_SKIP_EN
                if (skip_fwd) begin
                    if (cur_year_q == YEAR_MAX) begin
                        err_d    = 1'b1;
                        result_d = base_q;
                        state_d  = DONE;
                    end else begin
                        cur_year_d = cur_year_q + 14'd1;
                        rem_d      = rem_q - diy;
                    end
                end else
`endif
                if (rem_q <= dleft) begin
                    cur_day_d = cur_day_q + rem_q[4:0];
                    result_d  = {cur_year_q, cur_month_q, cur_day_q + rem_q[4:0]};
                    err_d     = 1'b0;
                    state_d   = DONE;
                end else if (cur_month_q == 4'd12 && cur_year_q == YEAR_MAX) begin
                    err_d    = 1'b1;
                    result_d = base_q;
                    state_d  = DONE;
                end else begin
                    // consume the rest of this month including today, land on the 1st of the next
                    rem_d     = rem_q - dleft - 17'd1;
                    cur_day_d = 5'd1;
                    if (cur_month_q == 4'd12) begin
                        cur_month_d = 4'd1;
                        cur_year_d  = cur_year_q + 14'd1;
                    end else begin
                        cur_month_d = cur_month_q + 4'd1;
                    end
                end
            end
            BWD: begin
`ifdef DATE_OFFSET_YEAR_SKIP_EN
                if (skip_bwd) begin
                    if (cur_year_q == 14'd1) begin
                        err_d    = 1'b1;
                        result_d = base_q;
                        state_d  = DONE;
                    end else begin
                        cur_year_d = cur_year_q - 14'd1;
                        rem_d      = rem_q - diy;
                    end
                end else
`endif
                if (rem_q < 17'(cur_day_q)) begin
                    cur_day_d = cur_day_q - rem_q[4:0];
                    result_d  = {cur_year_q, cur_month_q, cur_day_q - rem_q[4:0]};
                    err_d     = 1'b0;
                    state_d   = DONE;
                end else if (cur_month_q == 4'd1 && cur_year_q == 14'd1) begin
                    err_d    = 1'b1;
                    result_d = base_q;
                    state_d  = DONE;
                end else begin
                    rem_d       = rem_q - 17'(cur_day_q);
                    cur_month_d = prev_month;
                    cur_year_d  = prev_year;
                    cur_day_d   = prev_dim;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_year_q  <= '0;
            cur_month_q <= '0;
            cur_day_q   <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            base_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_year_q  <= cur_year_d;
            cur_month_q <= cur_month_d;
            cur_day_q   <= cur_day_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            base_q      <= base_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign busy        = (state_q == CHECK) || (state_q == FWD) || (state_q == BWD);
    assign done        = (state_q == DONE);
    assign result_date = result_q;
    assign err         = err_q;

endmodule

// File: tb/tb_date_offset_calc.sv
// Bench for date_offset_calc: vector table through a scoreboard queue plus protocol sequences.
module tb_date_offset_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [22:0] base_date;
    logic [16:0] offset;
    logic        busy;
    logic        done;
    logic [22:0] result_date;
    logic        err;

    date_offset_calc #(.MAX_OFFSET(99999)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dir         (dir),
        .base_date   (base_date),
        .offset      (offset),
        .busy        (busy),
        .done        (done),
        .result_date (result_date),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DATE_OFFSET_YEAR_SKIP_EN
    localparam int LONG_LAT = 34;
`else
    localparam int LONG_LAT = 331;
`endif

    typedef struct {
        logic [22:0] base;
        logic        dir;
        logic [16:0] off;
        logic [22:0] exp_date;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [22:0] date;
        logic        err;
        int          lat;
        int unsigned e0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [22:0] mk(input int y, input int m, input int d);
        return {y[13:0], m[3:0], d[4:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input vec_t v);
        exp_t e;
        @(negedge clk);
        e.date = v.exp_date;
        e.err  = v.exp_err;
        e.lat  = v.exp_lat;
        e.e0   = cyc;
        sb.push_back(e);
        base_date = v.base;
        dir       = v.dir;
        offset    = v.off;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 5000 cycles", name);
        end else begin
            check({name, "_date"}, {9'd0, result_date}, {9'd0, e.date});
            check({name, "_err"}, {31'd0, err}, {31'd0, e.err});
            check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            if (e.lat >= 0) check({name, "_latency"}, cyc - e.e0, e.lat);
        end
    endtask

    task automatic no_done_for(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(name, seen, 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{mk(2024, 1, 31), 1'b0, 17'd1,      mk(2024, 2, 1),   1'b0, 4};
        vecs[1]  = '{mk(2024, 2, 28), 1'b0, 17'd1,      mk(2024, 2, 29),  1'b0, 3};
        vecs[2]  = '{mk(2023, 2, 28), 1'b0, 17'd1,      mk(2023, 3, 1),   1'b0, 4};
        vecs[3]  = '{mk(1900, 2, 28), 1'b0, 17'd1,      mk(1900, 3, 1),   1'b0, 4};
        vecs[4]  = '{mk(2000, 2, 28), 1'b0, 17'd1,      mk(2000, 2, 29),  1'b0, 3};
        vecs[5]  = '{mk(2024, 3, 1),  1'b1, 17'd1,      mk(2024, 2, 29),  1'b0, 4};
        vecs[6]  = '{mk(2024, 1, 1),  1'b1, 17'd1,      mk(2023, 12, 31), 1'b0, 4};
        vecs[7]  = '{mk(2000, 1, 1),  1'b0, 17'd10000,  mk(2027, 5, 19),  1'b0, LONG_LAT};
        vecs[8]  = '{mk(2027, 5, 19), 1'b1, 17'd10000,  mk(2000, 1, 1),   1'b0, -1};
        vecs[9]  = '{mk(1, 1, 1),     1'b1, 17'd1,      mk(1, 1, 1),      1'b1, 3};
        vecs[10] = '{mk(2023, 2, 29), 1'b0, 17'd5,      mk(2023, 2, 29),  1'b1, 2};
        vecs[11] = '{mk(2024, 1, 1),  1'b0, 17'd100000, mk(2024, 1, 1),   1'b1, 2};
        vecs[12] = '{mk(2024, 7, 15), 1'b0, 17'd0,      mk(2024, 7, 15),  1'b0, 2};
        vecs[13] = '{mk(2024, 13, 1), 1'b0, 17'd1,      mk(2024, 13, 1),  1'b1, 2};
        vecs[14] = '{mk(0, 5, 5),     1'b0, 17'd1,      mk(0, 5, 5),      1'b1, 2};
        vecs[15] = '{mk(2024, 4, 0),  1'b1, 17'd1,      mk(2024, 4, 0),   1'b1, 2};
        vecs[16] = '{mk(2023, 12, 31), 1'b0, 17'd366,   mk(2024, 12, 31), 1'b0, -1};
        vecs[17] = '{mk(2024, 12, 31), 1'b1, 17'd366,   mk(2023, 12, 31), 1'b0, -1};
        vecs[18] = '{mk(2000, 1, 1),  1'b0, 17'd99999,  mk(2273, 10, 15), 1'b0, -1};
        vecs[19] = '{mk(1, 12, 31),   1'b1, 17'd400,    mk(1, 12, 31),    1'b1, -1};
        vecs[20] = '{mk(16383, 1, 1), 1'b0, 17'd400,    mk(16383, 1, 1),  1'b1, -1};

        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_date = '0; offset = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_result", {9'd0, result_date}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            launch(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end

        // start pulsed while busy must be ignored
        v = '{mk(2024, 1, 31), 1'b0, 17'd40, mk(2024, 3, 11), 1'b0, 5};
        launch(v);
        @(negedge clk);
        base_date = mk(1999, 6, 6); dir = 1'b1; offset = 17'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        no_done_for("ignore_start_no_extra_done", 10);

        // leave err=1 and a nonzero result before the abort test
        v = '{mk(16383, 12, 31), 1'b0, 17'd1, mk(16383, 12, 31), 1'b1, 3};
        launch(v);
        wait_done("overflow");

        @(negedge clk);
        base_date = mk(2000, 1, 1); dir = 1'b0; offset = 17'd10000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        check("mid_fwd_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_result", {9'd0, result_date}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        no_done_for("abort_no_done", 400);

        v = '{mk(2024, 2, 28), 1'b0, 17'd1, mk(2024, 2, 29), 1'b0, 3};
        launch(v);
        wait_done("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
